// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard controller.
package hazard_fwd_ctrl_pkg;

  // fwd_sel code meaning "take the operand from the register file"
  localparam int unsigned FWD_REGFILE = 0;

  // Width of a per-operand select: regfile plus one code per tracked stage.
  function automatic int unsigned sel_width(input int unsigned depth);
    return (depth + 1 > 1) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_src_match.sv
// One source operand against all scoreboard entries: youngest match wins and
// either forwards from its stage or, for a not-yet-ready load, requests a stall.
module hazard_src_match
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned SEL_W    = 2
) (
  input  logic [REG_W-1:0]       src,
  input  logic [DEPTH-1:0]       ent_valid,
  input  logic [DEPTH*REG_W-1:0] ent_dst,
  input  logic [DEPTH-1:0]       ent_load,
  output logic [SEL_W-1:0]       sel,
  output logic                   stall_req
);

  logic src_zero;
  logic found;

  assign src_zero = (ZERO_REG != 0) && (src == '0);

  always_comb begin
    sel       = SEL_W'(FWD_REGFILE);
    stall_req = 1'b0;
    found     = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found && !src_zero && ent_valid[k] &&
          (ent_dst[k*REG_W +: REG_W] == src)) begin
        found = 1'b1;
        // A load still short of its latency cannot forward yet.
        if (ent_load[k] && (k < LOAD_LAT)) begin
          stall_req = 1'b1;
        end else begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding / load-use hazard controller: scoreboard of in-flight producers,
// per-operand forwarding select, stall/bubble generation and stall counter.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter  int unsigned REG_W    = 4,
  parameter  int unsigned NUM_SRC  = 2,
  parameter  int unsigned DEPTH    = 2,
  parameter  int unsigned LOAD_LAT = 1,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned SEL_W    = sel_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idex_valid,
  input  logic [NUM_SRC*REG_W-1:0] idex_src,
  input  logic [REG_W-1:0]         idex_dst,
  input  logic                     idex_wen,
  input  logic                     idex_is_load,
  input  logic                     hold,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic                     bubble,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [DEPTH-1:0]       ent_valid_q, ent_valid_d;
  logic [DEPTH*REG_W-1:0] ent_dst_q,   ent_dst_d;
  logic [DEPTH-1:0]       ent_load_q,  ent_load_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]     stall_req;
  logic                   new_ok;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .REG_W    (REG_W),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_match (
      .src       (idex_src[i*REG_W +: REG_W]),
      .ent_valid (ent_valid_q),
      .ent_dst   (ent_dst_q),
      .ent_load  (ent_load_q),
      .sel       (fwd_sel[i*SEL_W +: SEL_W]),
      .stall_req (stall_req[i])
    );
  end

  // Flush and hold both override a pending load-use stall.
  assign stall  = idex_valid && !flush && !hold && (|stall_req);
  assign bubble = !hold && (stall || flush);

  assign new_ok = idex_valid && idex_wen && !stall && !flush &&
                  !((ZERO_REG != 0) && (idex_dst == '0));

  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_dst_d   = ent_dst_q;
    ent_load_d  = ent_load_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        ent_valid_d[k]                = ent_valid_q[k-1];
        ent_dst_d[k*REG_W +: REG_W]   = ent_dst_q[(k-1)*REG_W +: REG_W];
        ent_load_d[k]                 = ent_load_q[k-1];
      end
      ent_valid_d[0]         = new_ok;
      ent_dst_d[0 +: REG_W]  = new_ok ? idex_dst : '0;
      ent_load_d[0]          = new_ok && idex_is_load;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid_q <= '0;
      ent_dst_q   <= '0;
      ent_load_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_dst_q   <= ent_dst_d;
      ent_load_q  <= ent_load_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
